video_pattern_gen: RTL and testbench

Parametrised successor to the fixed colour-bar source used in the Parallel2CSI2 benches and bring-up builds. It produces a parallel camera-style video stream (fv, lv, data, hsync, vsync) with configurable geometry and data width, and four runtime-selectable patterns. It adds frame gating, frame counting and a start-of-frame strobe. It sits directly on the PIXCLK/FV/LV/PIXDATA inputs of the CSI-2 transmitter top.

---
 rtl/video_pattern_gen.sv | 161 ++++++++++++++++
 tb/tb_video_pattern_gen.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_pattern_gen.sv
// Parallel camera-style video source: H/V timing counters with registered decode,
// four selectable test patterns, frame gating on en, frame counter and SOF strobe.
module video_pattern_gen #(
   parameter int DATA_W        = 12,
   parameter int H_ACTIVE      = 480,
   parameter int H_TOTAL       = 800,
   parameter int V_ACTIVE      = 800,
   parameter int V_TOTAL       = 830,
   parameter int H_FRONT_PORCH = 40,
   parameter int H_SYNCH       = 44,
   parameter int V_FRONT_PORCH = 5,
   parameter int V_SYNCH       = 5,
   parameter int CHK_LOG2      = 4,
   parameter logic [DATA_W-1:0] SOLID_VAL = DATA_W'(12'h800)
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              en,
   input  logic [1:0]        mode,
   output logic              fv,
   output logic              lv,
   output logic [DATA_W-1:0] data,
   output logic              hsync,
   output logic              vsync,
   output logic              sof,
   output logic [15:0]       frame_cnt
);
   localparam int HW       = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
   localparam int VW       = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;
   localparam int BW       = H_ACTIVE / 8;
   localparam int BWW      = (BW > 1) ? $clog2(BW) : 1;
   localparam int HS_START = H_ACTIVE + H_FRONT_PORCH;
   localparam int HS_END   = HS_START + H_SYNCH;
   localparam int VS_START = V_ACTIVE + V_FRONT_PORCH;
   localparam int VS_END   = VS_START + V_SYNCH;
   localparam logic [HW-1:0]  H_LAST  = HW'(H_TOTAL - 1);
   localparam logic [VW-1:0]  V_LAST  = VW'(V_TOTAL - 1);
   localparam logic [BWW-1:0] BW_LAST = BWW'(BW - 1);

   typedef enum logic {S_IDLE, S_RUN} state_t;

   state_t            state_q, state_d;
   logic [HW-1:0]     h_q, h_d;
   logic [VW-1:0]     v_q, v_d;
   logic [1:0]        mode_q, mode_d;
   logic [15:0]       fcnt_q, fcnt_d;
   logic [BWW-1:0]    bw_q, bw_d;
   logic [2:0]        b_q, b_d;
   logic              fv_q, fv_d, lv_q, lv_d, hs_q, hs_d, vs_q, vs_d, sof_q, sof_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [31:0]       hx, vx;
   logic              run, line_end, frame_end;

   always_comb begin
      hx        = 32'(h_q);
      vx        = 32'(v_q);
      run       = (state_q == S_RUN);
      line_end  = (h_q == H_LAST);
      frame_end = line_end && (v_q == V_LAST);

      // Output decode of the current counter position, registered below.
      fv_d  = run && (vx < V_ACTIVE);
      lv_d  = fv_d && (hx < H_ACTIVE);
      hs_d  = run && (hx >= HS_START) && (hx < HS_END);
      vs_d  = run && (vx >= VS_START) && (vx < VS_END);
      sof_d = run && (h_q == '0) && (v_q == '0);
      data_d = '0;
      if (lv_d) begin
         unique case (mode_q)
            2'd0: data_d = {3'(3'd7 - b_q), {(DATA_W-3){1'b0}}};
            2'd1: data_d = DATA_W'(hx + 32'(fcnt_q));
            2'd2: data_d = (hx[CHK_LOG2] ^ vx[CHK_LOG2]) ? {DATA_W{1'b1}} : '0;
            default: data_d = SOLID_VAL;
         endcase
      end

      state_d = state_q;
      h_d     = h_q;
      v_d     = v_q;
      mode_d  = mode_q;
      fcnt_d  = fcnt_q;
      bw_d    = bw_q;
      b_d     = b_q;
      unique case (state_q)
         S_IDLE: begin
            h_d  = '0;
            v_d  = '0;
            bw_d = '0;
            b_d  = '0;
            if (en) begin
               state_d = S_RUN;
               mode_d  = mode;
            end
         end
         default: begin
            if (line_end) begin
               h_d  = '0;
               bw_d = '0;
               b_d  = '0;
               if (frame_end) begin
                  v_d    = '0;
                  fcnt_d = fcnt_q + 16'd1;
                  if (en) mode_d  = mode;
                  else    state_d = S_IDLE;
               end else begin
                  v_d = v_q + 1'b1;
               end
            end else begin
               h_d = h_q + 1'b1;
               // Bar index steps every BW pixels; wraps harmlessly past the active region.
               if (bw_q == BW_LAST) begin
                  bw_d = '0;
                  b_d  = b_q + 3'd1;
               end else begin
                  bw_d = bw_q + 1'b1;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= S_IDLE;
         h_q     <= '0;
         v_q     <= '0;
         mode_q  <= '0;
         fcnt_q  <= '0;
         bw_q    <= '0;
         b_q     <= '0;
         fv_q    <= 1'b0;
         lv_q    <= 1'b0;
         hs_q    <= 1'b0;
         vs_q    <= 1'b0;
         sof_q   <= 1'b0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         h_q     <= h_d;
         v_q     <= v_d;
         mode_q  <= mode_d;
         fcnt_q  <= fcnt_d;
         bw_q    <= bw_d;
         b_q     <= b_d;
         fv_q    <= fv_d;
         lv_q    <= lv_d;
         hs_q    <= hs_d;
         vs_q    <= vs_d;
         sof_q   <= sof_d;
         data_q  <= data_d;
      end
   end

   assign fv        = fv_q;
   assign lv        = lv_q;
   assign data      = data_q;
   assign hsync     = hs_q;
   assign vsync     = vs_q;
   assign sof       = sof_q;
   assign frame_cnt = fcnt_q;
endmodule

// File: tb/tb_video_pattern_gen.sv
// Bench for video_pattern_gen: directed scenario tasks plus randomized en/mode traffic,
// all checked against a pixel-index reference model of the frame.
module tb_video_pattern_gen;
   localparam int DW = 12, H_ACT = 8, H_TOT = 16, V_ACT = 4, V_TOT = 6;
   localparam int HFP = 2, HS = 3, VFP = 1, VS = 1, CHK = 1;

   logic        clk = 1'b0, rstn = 1'b0, en = 1'b0;
   logic [1:0]  mode = 2'd0;
   logic        fv, lv, hsync, vsync, sof;
   logic [DW-1:0] data;
   logic [15:0] frame_cnt;
   int          n_cmp = 0, n_bad = 0;

   video_pattern_gen #(
      .DATA_W(DW), .H_ACTIVE(H_ACT), .H_TOTAL(H_TOT), .V_ACTIVE(V_ACT), .V_TOTAL(V_TOT),
      .H_FRONT_PORCH(HFP), .H_SYNCH(HS), .V_FRONT_PORCH(VFP), .V_SYNCH(VS), .CHK_LOG2(CHK)
   ) dut (
      .clk(clk), .rstn(rstn), .en(en), .mode(mode), .fv(fv), .lv(lv), .data(data),
      .hsync(hsync), .vsync(vsync), .sof(sof), .frame_cnt(frame_cnt)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic fv; logic lv; logic [DW-1:0] data; logic hs; logic vs; logic sof;
   } vout_t;

   // Expected outputs for pixel (x,y) of a frame, straight from the pattern rules.
   function automatic vout_t pix(int x, int y, int md, int fc);
      vout_t r;
      r     = '0;
      r.fv  = (y < V_ACT);
      r.lv  = r.fv && (x < H_ACT);
      r.hs  = (x >= H_ACT + HFP) && (x < H_ACT + HFP + HS);
      r.vs  = (y >= V_ACT + VFP) && (y < V_ACT + VFP + VS);
      r.sof = (x == 0) && (y == 0);
      if (r.lv) begin
         case (md)
            0: r.data = DW'((7 - x / (H_ACT / 8)) << (DW - 3));
            1: r.data = DW'((x + fc) % (1 << DW));
            2: r.data = ((((x >> CHK) ^ (y >> CHK)) & 1) != 0) ? {DW{1'b1}} : '0;
            default: r.data = 12'h800;
         endcase
      end
      return r;
   endfunction

   logic        m_run;
   int          m_p;
   int          m_mode;
   logic [15:0] m_fc;
   vout_t       m_out;

   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         m_run <= 1'b0; m_p <= 0; m_mode <= 0; m_fc <= '0; m_out <= '0;
      end else if (!m_run) begin
         m_out <= '0;
         if (en) begin m_run <= 1'b1; m_p <= 0; m_mode <= int'(mode); end
      end else begin
         m_out <= pix(m_p % H_TOT, m_p / H_TOT, m_mode, int'(m_fc));
         if (m_p == H_TOT * V_TOT - 1) begin
            m_p  <= 0;
            m_fc <= m_fc + 16'd1;
            if (en) m_mode <= int'(mode);
            else    m_run  <= 1'b0;
         end else begin
            m_p <= m_p + 1;
         end
      end
   end

   wire [32:0] dut_bus = {fv, lv, data, hsync, vsync, sof, frame_cnt};
   wire [32:0] mdl_bus = {m_out, m_fc};

   task automatic wait_sof(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (sof) begin ok = 1'b1; break; end
      end
   endtask

   task automatic test_reset();
      rstn = 1'b0; en = 1'b1; mode = 2'd0;
      repeat (3) @(negedge clk);
      n_cmp++;
      if (dut_bus !== 33'd0) begin n_bad++; $display("FAIL reset_outputs got %h want 0", dut_bus); end
      rstn = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (fv !== 1'b0) begin n_bad++; $display("FAIL e0_still_idle got fv=%b want 0", fv); end
      @(negedge clk);
      n_cmp++;
      if ({fv, lv, sof, data} !== {3'b111, 12'hE00})
         begin n_bad++; $display("FAIL e1_start got fv/lv/sof=%b%b%b data=%h want 111 E00", fv, lv, sof, data); end
      @(negedge clk);
      n_cmp++;
      if ({sof, lv, data} !== {2'b01, 12'hC00})
         begin n_bad++; $display("FAIL e2_sof_low got sof=%b lv=%b data=%h want 0 1 C00", sof, lv, data); end
      repeat (20) begin
         @(negedge clk);
         n_cmp++;
         if (dut_bus !== mdl_bus) begin n_bad++; $display("FAIL reset_run got %h want %h", dut_bus, mdl_bus); end
      end
   endtask

   task automatic test_geometry();
      bit ok;
      int c_fv = 0, c_lv = 0, c_hs = 0, c_vs = 0;
      wait_sof(ok);
      n_cmp++;
      if (!ok) begin n_bad++; $display("FAIL geom_sof_timeout got none want sof"); end
      for (int k = 0; k < H_TOT * V_TOT; k++) begin
         if (k > 0) @(negedge clk);
         c_fv += int'(fv); c_lv += int'(lv); c_hs += int'(hsync); c_vs += int'(vsync);
         n_cmp++;
         if (hsync !== ((k % 16) >= 10 && (k % 16) <= 12))
            begin n_bad++; $display("FAIL geom_hsync k=%0d got %b", k, hsync); end
         n_cmp++;
         if (dut_bus !== mdl_bus) begin n_bad++; $display("FAIL geom_model k=%0d got %h want %h", k, dut_bus, mdl_bus); end
      end
      @(negedge clk);
      n_cmp++;
      if (sof !== 1'b1) begin n_bad++; $display("FAIL geom_frame_period got sof=%b want 1 at 96", sof); end
      n_cmp++;
      if ({c_fv, c_lv, c_hs, c_vs} !== {32'd64, 32'd32, 32'd18, 32'd16})
         begin n_bad++; $display("FAIL geom_counts got fv=%0d lv=%0d hs=%0d vs=%0d want 64 32 18 16", c_fv, c_lv, c_hs, c_vs); end
   endtask

   task automatic test_bars();
      bit ok;
      logic [DW-1:0] tbl [8] = '{12'hE00, 12'hC00, 12'hA00, 12'h800, 12'h600, 12'h400, 12'h200, 12'h000};
      wait_sof(ok);
      n_cmp++;
      if (!ok) begin n_bad++; $display("FAIL bars_sof_timeout got none want sof"); end
      for (int x = 0; x < H_TOT; x++) begin
         if (x > 0) @(negedge clk);
         n_cmp++;
         if (data !== ((x < H_ACT) ? tbl[x] : 12'h000))
            begin n_bad++; $display("FAIL bars x=%0d got %h want %h", x, data, (x < H_ACT) ? tbl[x] : 12'h000); end
      end
   endtask

   task automatic test_ramp();
      bit ok;
      rstn = 1'b0; mode = 2'd1; en = 1'b1;
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      for (int x = 0; x < H_ACT; x++) begin
         @(negedge clk);
         n_cmp++;
         if ({data, frame_cnt} !== {DW'(x), 16'd0})
            begin n_bad++; $display("FAIL ramp_f0 x=%0d got %h/%0d want %h/0", x, data, frame_cnt, x); end
      end
      wait_sof(ok);
      n_cmp++;
      if (!ok || frame_cnt !== 16'd1)
         begin n_bad++; $display("FAIL ramp_fcnt got ok=%b cnt=%0d want 1", ok, frame_cnt); end
      for (int x = 0; x < H_ACT; x++) begin
         if (x > 0) @(negedge clk);
         n_cmp++;
         if (data !== DW'(x + 1)) begin n_bad++; $display("FAIL ramp_f1 x=%0d got %h want %h", x, data, x + 1); end
      end
   endtask

   task automatic test_checker();
      bit ok;
      logic [DW-1:0] chk0 [8] = '{12'h000, 12'h000, 12'hFFF, 12'hFFF, 12'h000, 12'h000, 12'hFFF, 12'hFFF};
      mode = 2'd2;
      @(negedge clk);
      wait_sof(ok);
      n_cmp++;
      if (!ok) begin n_bad++; $display("FAIL chk_sof_timeout got none want sof"); end
      for (int k = 0; k < 40; k++) begin
         if (k > 0) @(negedge clk);
         if (k < 8) begin
            n_cmp++;
            if (data !== chk0[k]) begin n_bad++; $display("FAIL chk_line0 x=%0d got %h want %h", k, data, chk0[k]); end
         end else if (k >= 32) begin
            n_cmp++;
            if (data !== ~chk0[k-32]) begin n_bad++; $display("FAIL chk_line2 x=%0d got %h want %h", k - 32, data, ~chk0[k-32]); end
         end
         n_cmp++;
         if (dut_bus !== mdl_bus) begin n_bad++; $display("FAIL chk_model k=%0d got %h want %h", k, dut_bus, mdl_bus); end
      end
   endtask

   task automatic test_gating();
      bit ok;
      logic [15:0] fc0;
      int stuck = 0;
      mode = 2'd0;
      @(negedge clk);
      wait_sof(ok);
      repeat (20) @(negedge clk);
      en = 1'b0; mode = 2'd3; fc0 = frame_cnt;
      repeat (28) @(negedge clk);
      n_cmp++;
      if ({lv, data} !== {1'b1, 12'hE00}) begin n_bad++; $display("FAIL gate_keeps_bars got lv=%b data=%h want 1 E00", lv, data); end
      repeat (47) @(negedge clk);
      n_cmp++;
      if ({fv, vsync} !== 2'b01) begin n_bad++; $display("FAIL gate_last_pixel got fv=%b vs=%b want 0 1", fv, vsync); end
      @(negedge clk);
      n_cmp++;
      if (dut_bus !== {17'd0, 16'(fc0 + 16'd1)}) begin n_bad++; $display("FAIL gate_idle got %h want cnt %0d", dut_bus, fc0 + 16'd1); end
      repeat (40) begin @(negedge clk); if (fv !== 1'b0 || frame_cnt !== fc0 + 16'd1) stuck++; end
      n_cmp++;
      if (stuck != 0) begin n_bad++; $display("FAIL gate_stays_idle got %0d bad cycles want 0", stuck); end
      en = 1'b1;
      wait_sof(ok);
      n_cmp++;
      if (!ok) begin n_bad++; $display("FAIL gate_restart got none want sof"); end
      for (int x = 0; x < H_ACT; x++) begin
         if (x > 0) @(negedge clk);
         n_cmp++;
         if (data !== 12'h800) begin n_bad++; $display("FAIL gate_solid x=%0d got %h want 800", x, data); end
      end
      repeat (11) @(negedge clk);
      n_cmp++;
      if (lv !== 1'b1) begin n_bad++; $display("FAIL gate_midline got lv=%b want 1", lv); end
      #2 rstn = 1'b0;
      #1;
      n_cmp++;
      if (dut_bus !== 33'd0) begin n_bad++; $display("FAIL gate_async_reset got %h want 0", dut_bus); end
      @(negedge clk);
      en = 1'b0; rstn = 1'b1;
      stuck = 0;
      repeat (5) begin @(negedge clk); if (fv !== 1'b0) stuck++; end
      n_cmp++;
      if (stuck != 0) begin n_bad++; $display("FAIL gate_no_autostart got %0d fv cycles want 0", stuck); end
      en = 1'b1;
      repeat (2) @(negedge clk);
      n_cmp++;
      if ({sof, frame_cnt} !== {1'b1, 16'd0}) begin n_bad++; $display("FAIL gate_rerun got sof=%b cnt=%0d want 1 0", sof, frame_cnt); end
   endtask

   task automatic test_random();
      for (int i = 0; i < 1500; i++) begin
         @(negedge clk);
         n_cmp++;
         if (dut_bus !== mdl_bus) begin n_bad++; $display("FAIL rand_model i=%0d got %h want %h", i, dut_bus, mdl_bus); end
         if (i % 37 == 0) en = ($urandom_range(0, 7) != 0);
         if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
      end
   endtask

   initial begin
      test_reset();
      test_geometry();
      test_bars();
      test_ramp();
      test_checker();
      test_gating();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
